// File: rtl/data_mem_io.sv
// Data-side bus responder for the 16-bit CPU: word-addressed RAM plus a small
// I/O page (GPIO output/input and a compare timer). Reads are combinational;
// each distinct store is committed exactly once, even if the CPU holds it.
module data_mem_io #(
  parameter int unsigned RAM_AW  = 8,
  parameter logic [15:0] IO_BASE = 16'hFF00
) (
  input  logic        CK,
  input  logic        RST,
  input  logic [15:0] DA,
  inout  wire  [15:0] DD,
  input  logic        RW,
  input  logic [15:0] GPIO_IN,
  output logic [15:0] GPIO_OUT,
  output logic        TIMER_IRQ
);

  localparam int DATA_W    = 16;
  localparam int RAM_DEPTH = 1 << RAM_AW;

  logic [DATA_W-1:0] ram [RAM_DEPTH];

  // Previous-edge bus state used to spot a new store
  logic              rw_q;
  logic [DATA_W-1:0] da_q;
  logic [DATA_W-1:0] dd_q;

  // Two-stage synchroniser for the external inputs
  logic [DATA_W-1:0] gpio_sync_p0;
  logic [DATA_W-1:0] gpio_sync_p1;

  logic [DATA_W-1:0] gpio_out;
  logic [DATA_W-1:0] tmr_cnt;
  logic [DATA_W-1:0] tmr_cmp;
  logic              tmr_en;
  logic              tmr_reload;
  logic              match;

  logic              is_ram;
  logic              is_io;
  logic [DATA_W-1:0] io_off;
  logic [2:0]        io_sel;
  logic [DATA_W-1:0] rdata;
  logic              commit;
  logic              wr_ram;
  logic              wr_gpio;
  logic              wr_cnt;
  logic              wr_cmp;
  logic              wr_ctrl;
  logic              wr_status;
  logic              tmr_hit;

  assign is_ram = {1'b0, DA} < 17'(RAM_DEPTH);
  assign io_off = DA - IO_BASE;
  assign is_io  = (DA >= IO_BASE) && (io_off < 16'd6);
  assign io_sel = io_off[2:0];

  // A store is new when RW just fell or the address/data changed since last edge
  assign commit    = !RST && !RW && (rw_q || (DA != da_q) || (DD != dd_q));
  assign wr_ram    = commit && is_ram;
  assign wr_gpio   = commit && !is_ram && is_io && (io_sel == 3'd0);
  assign wr_cnt    = commit && !is_ram && is_io && (io_sel == 3'd2);
  assign wr_cmp    = commit && !is_ram && is_io && (io_sel == 3'd3);
  assign wr_ctrl   = commit && !is_ram && is_io && (io_sel == 3'd4);
  assign wr_status = commit && !is_ram && is_io && (io_sel == 3'd5);

  assign tmr_hit   = tmr_en && (tmr_cnt == tmr_cmp);

  // Combinational read mux; unmapped addresses read as zero
  always_comb begin
    rdata = '0;
    if (is_ram) begin
      rdata = ram[DA[RAM_AW-1:0]];
    end else if (is_io) begin
      case (io_sel)
        3'd0:    rdata = gpio_out;
        3'd1:    rdata = gpio_sync_p1;
        3'd2:    rdata = tmr_cnt;
        3'd3:    rdata = tmr_cmp;
        3'd4:    rdata = {14'b0, tmr_reload, tmr_en};
        3'd5:    rdata = {15'b0, match};
        default: rdata = '0;
      endcase
    end
  end

  assign DD        = (RW && !RST) ? rdata : {DATA_W{1'bz}};
  assign GPIO_OUT  = gpio_out;
  assign TIMER_IRQ = match;

  // RAM array: written on a committed store, never reset
  always_ff @(posedge CK) begin
    if (wr_ram) begin
      ram[DA[RAM_AW-1:0]] <= DD;
    end
  end

  // Edge-detect history, GPIO output register and input synchroniser
  always_ff @(posedge CK) begin
    if (RST) begin
      rw_q         <= 1'b1;
      da_q         <= '0;
      dd_q         <= '0;
      gpio_out     <= '0;
      gpio_sync_p0 <= '0;
      gpio_sync_p1 <= '0;
    end else begin
      rw_q         <= RW;
      da_q         <= DA;
      dd_q         <= DD;
      // stage p0 -> p1 boundary
      gpio_sync_p0 <= GPIO_IN;
      gpio_sync_p1 <= gpio_sync_p0;
      if (wr_gpio) begin
        gpio_out <= DD;
      end
    end
  end

  // Compare timer; CPU writes to CNT/CTRL override the timer's own update,
  // and a match on the same edge wins over a write-1-to-clear of MATCH
  always_ff @(posedge CK) begin
    if (RST) begin
      tmr_cnt    <= '0;
      tmr_cmp    <= 16'hFFFF;
      tmr_en     <= 1'b0;
      tmr_reload <= 1'b0;
      match      <= 1'b0;
    end else begin
      if (tmr_hit) begin
        match <= 1'b1;
        if (tmr_reload) begin
          tmr_cnt <= '0;
        end else begin
          tmr_en <= 1'b0;
        end
      end else begin
        if (tmr_en) begin
          tmr_cnt <= tmr_cnt + 16'd1;
        end
        if (wr_status && DD[0]) begin
          match <= 1'b0;
        end
      end
      if (wr_cnt) begin
        tmr_cnt <= DD;
      end
      if (wr_cmp) begin
        tmr_cmp <= DD;
      end
      if (wr_ctrl) begin
        tmr_en     <= DD[0];
        tmr_reload <= DD[1];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_io.sv
// Self-checking bench for data_mem_io: directed scenarios followed by random
// bus traffic, all compared against a behavioural memory-map model.
module tb_data_mem_io;

  localparam logic [15:0] IO_BASE = 16'hFF00;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        RW = 1'b1;
  logic [15:0] DA = '0;
  logic [15:0] GPIO_IN = '0;
  logic [15:0] GPIO_OUT;
  logic        TIMER_IRQ;
  wire  [15:0] DD;
  logic [15:0] dd_drv = '0;
  logic        dd_en = 1'b0;

  assign DD = dd_en ? dd_drv : 16'hzzzz;

  data_mem_io #(.RAM_AW(8), .IO_BASE(IO_BASE)) dut (
    .CK(CK), .RST(RST), .DA(DA), .DD(DD), .RW(RW),
    .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT), .TIMER_IRQ(TIMER_IRQ)
  );

  always #5 CK = ~CK;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model of the memory map
  logic [15:0] m_ram [256];
  bit          m_ram_ok [256];
  logic [15:0] m_gpio, m_cnt, m_cmp;
  bit          m_en, m_rl, m_match;
  logic [15:0] m_in_hist [2];
  bit          m_prev_rw;
  logic [15:0] m_prev_da, m_prev_dd;

  function automatic logic [15:0] m_read(input logic [15:0] a, output bit ok);
    ok = 1'b1;
    if (a < 16'd256) begin
      ok = m_ram_ok[a[7:0]];
      return m_ram[a[7:0]];
    end
    case (a)
      IO_BASE:          return m_gpio;
      IO_BASE + 16'd1:  return m_in_hist[1];
      IO_BASE + 16'd2:  return m_cnt;
      IO_BASE + 16'd3:  return m_cmp;
      IO_BASE + 16'd4:  return {14'b0, m_rl, m_en};
      IO_BASE + 16'd5:  return {15'b0, m_match};
      default:          return 16'h0000;
    endcase
  endfunction

  task automatic m_step(input bit rst, input bit rw, input logic [15:0] da, input logic [15:0] bus);
    bit store;
    bit hit;
    if (rst) begin
      m_gpio = 0; m_cnt = 0; m_cmp = 16'hFFFF; m_en = 0; m_rl = 0; m_match = 0;
      m_in_hist[0] = 0; m_in_hist[1] = 0;
      m_prev_rw = 1; m_prev_da = 0; m_prev_dd = 0;
      return;
    end
    store = !rw && (m_prev_rw || da != m_prev_da || bus != m_prev_dd);
    hit   = m_en && (m_cnt == m_cmp);
    if (hit) begin
      m_match = 1;
      if (m_rl) m_cnt = 0;
      else      m_en  = 0;
    end else if (m_en) begin
      m_cnt = m_cnt + 16'd1;
    end
    if (store) begin
      if (da < 16'd256) begin
        m_ram[da[7:0]]    = bus;
        m_ram_ok[da[7:0]] = 1'b1;
      end else begin
        case (da)
          IO_BASE:         m_gpio = bus;
          IO_BASE + 16'd2: m_cnt  = bus;
          IO_BASE + 16'd3: m_cmp  = bus;
          IO_BASE + 16'd4: begin m_en = bus[0]; m_rl = bus[1]; end
          IO_BASE + 16'd5: if (bus[0] && !hit) m_match = 0;
          default: ;
        endcase
      end
    end
    m_in_hist[1] = m_in_hist[0];
    m_in_hist[0] = GPIO_IN;
    m_prev_rw = rw; m_prev_da = da; m_prev_dd = bus;
  endtask

  logic [15:0] obs_dd;
  logic [15:0] obs_gpio;
  logic        obs_irq;

  // One bus cycle: apply inputs after the falling edge, check, then clock
  task automatic drive(input bit rst, input bit rw, input logic [15:0] da, input logic [15:0] dd);
    logic [15:0] exp;
    bit ok;
    RST = rst; RW = rw; DA = da;
    dd_en  = !rw || rst;
    dd_drv = rw ? 16'h0000 : dd;
    #1;
    obs_dd = DD; obs_gpio = GPIO_OUT; obs_irq = TIMER_IRQ;
    exp = m_read(da, ok);
    if (chk_on) begin
      check("gpio_out", GPIO_OUT, m_gpio);
      check("timer_irq", {15'b0, TIMER_IRQ}, {15'b0, m_match});
      if (dd_en)   check("dd_release", DD, dd_drv);
      else if (ok) check("dd_read", DD, exp);
    end
    @(posedge CK);
    m_step(rst, rw, da, dd_en ? dd_drv : exp);
    @(negedge CK);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, observed running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    bit          h_rw;
    logic [15:0] h_da, h_dd;
    bit          r_rst;

    @(negedge CK);
    drive(1, 1, IO_BASE + 16'd3, 0);
    chk_on = 1'b1;
    drive(1, 1, IO_BASE + 16'd3, 0);
    check("rst_dd_z", obs_dd, 16'h0000);
    drive(0, 1, IO_BASE + 16'd3, 0);
    check("rst_cmp", obs_dd, 16'hFFFF);
    check("rst_irq", {15'b0, obs_irq}, 16'h0000);

    // RAM
    drive(0, 0, 16'h0010, 16'hA5A5);
    drive(0, 0, 16'h0011, 16'h1234);
    drive(0, 1, 16'h0010, 0);
    check("ram_10", obs_dd, 16'hA5A5);
    drive(0, 1, 16'h0011, 0);
    check("ram_11", obs_dd, 16'h1234);
    drive(0, 1, 16'h0200, 0);
    check("unmapped", obs_dd, 16'h0000);

    // Held store to CNT while the timer runs
    drive(0, 0, IO_BASE + 16'd4, 16'h0001);
    for (int k = 0; k < 4; k++) drive(0, 0, IO_BASE + 16'd2, 16'h0005);
    drive(0, 1, IO_BASE + 16'd2, 0);
    check("held_cnt", obs_dd, 16'h0008);
    drive(0, 0, IO_BASE + 16'd4, 16'h0000);

    // One-shot timer
    drive(0, 0, IO_BASE + 16'd3, 16'h0003);
    drive(0, 0, IO_BASE + 16'd2, 16'h0000);
    drive(0, 0, IO_BASE + 16'd4, 16'h0001);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, IO_BASE + 16'd5, 0);
      check("oneshot_irq", {15'b0, obs_irq}, (k == 4) ? 16'h0001 : 16'h0000);
    end
    drive(0, 1, IO_BASE + 16'd2, 0);
    check("oneshot_cnt", obs_dd, 16'h0003);
    drive(0, 1, IO_BASE + 16'd4, 0);
    check("oneshot_ctrl", obs_dd, 16'h0000);
    drive(0, 0, IO_BASE + 16'd5, 16'h0001);
    drive(0, 1, IO_BASE + 16'd5, 0);
    check("status_clr", {15'b0, obs_irq}, 16'h0000);

    // Reload timer and clear-vs-match race
    drive(0, 0, IO_BASE + 16'd3, 16'h0002);
    drive(0, 0, IO_BASE + 16'd2, 16'h0000);
    drive(0, 0, IO_BASE + 16'd4, 16'h0003);
    drive(0, 1, IO_BASE + 16'd5, 0);
    drive(0, 1, IO_BASE + 16'd5, 0);
    drive(0, 1, IO_BASE + 16'd5, 0);
    drive(0, 0, IO_BASE + 16'd5, 16'h0001);
    check("reload_irq", {15'b0, obs_irq}, 16'h0001);
    drive(0, 1, IO_BASE + 16'd5, 0);
    check("reload_clr", {15'b0, obs_irq}, 16'h0000);
    drive(0, 0, IO_BASE + 16'd5, 16'h0001);
    drive(0, 1, IO_BASE + 16'd5, 0);
    check("clear_race", {15'b0, obs_irq}, 16'h0001);
    drive(0, 0, IO_BASE + 16'd4, 16'h0000);
    drive(0, 0, IO_BASE + 16'd5, 16'h0001);

    // GPIO
    drive(0, 0, IO_BASE, 16'hBEEF);
    drive(0, 1, IO_BASE, 0);
    check("gpio_beef", obs_gpio, 16'hBEEF);
    GPIO_IN = 16'h00F0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, IO_BASE + 16'd1, 0);
      check("gpio_in_sync", obs_dd, (k == 2) ? 16'h00F0 : 16'h0000);
    end

    // Reset in the middle of a held store
    drive(0, 0, IO_BASE, 16'h1111);
    drive(0, 0, IO_BASE, 16'h1111);
    drive(1, 0, IO_BASE, 16'h1111);
    drive(1, 1, IO_BASE + 16'd3, 0);
    check("rst_gpio", obs_gpio, 16'h0000);
    check("rst_mid_dd_z", obs_dd, 16'h0000);
    drive(1, 0, IO_BASE, 16'h2222);
    for (int k = 0; k < 3; k++) drive(0, 0, IO_BASE, 16'h2222);
    drive(0, 1, IO_BASE + 16'd3, 0);
    check("rst_cmp_ffff", obs_dd, 16'hFFFF);
    check("post_rst_store", obs_gpio, 16'h2222);

    // Random traffic
    h_rw = 1; h_da = 0; h_dd = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) >= 4) begin
        h_rw = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
          0:       h_da = 16'($urandom_range(0, 15));
          1:       h_da = 16'($urandom_range(0, 255));
          2, 3:    h_da = IO_BASE + 16'($urandom_range(0, 5));
          4:       h_da = IO_BASE + 16'($urandom_range(6, 255));
          default: h_da = 16'($urandom_range(256, 16'hFEFF));
        endcase
        h_dd = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      end
      r_rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) GPIO_IN = 16'($urandom);
      drive(r_rst, h_rw, h_da, h_dd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
